// File: rtl/store_drain_ctrl.sv
// Store queue: lane-aligns committed stores into a DEPTH-entry FIFO and issues them to dmem over req/ack.
// dmem_req rises one edge after the first enqueue; st_ready drops while full, with no bypass on a same-cycle pop.
module store_drain_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_sel,
    output logic                     st_ready,
    output logic                     dmem_req,
    output logic [31:0]              dmem_addr,
    output logic [31:0]              dmem_wdata,
    output logic [3:0]               dmem_we,
    input  logic                     dmem_ack,
    output logic                     drain_idle,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  mask;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [0:0]      state_q, state_d;

    entry_t          enq_entry;
    entry_t          head;
    logic [1:0]      offset;
    logic            enq;
    logic            pop;

    // Lane alignment happens once at enqueue so the issue path is a plain register read.
    always_comb begin
        offset          = st_addr[1:0];
        enq_entry       = '0;
        enq_entry.waddr = st_addr[31:2];
        case (st_sel)
            2'b00: begin
                enq_entry.data = st_data << {offset, 3'b000};
                enq_entry.mask = 4'b0001 << offset;
            end
            2'b01: begin
                case (offset)
                    2'b00: begin
                        enq_entry.data = st_data;
                        enq_entry.mask = 4'b0011;
                    end
                    2'b01: begin
                        enq_entry.data = st_data << 8;
                        enq_entry.mask = 4'b0110;
                    end
                    default: begin
                        enq_entry.data = st_data << 16;
                        enq_entry.mask = 4'b1100;
                    end
                endcase
            end
            default: begin
                enq_entry.data = st_data;
                enq_entry.mask = 4'b1111;
            end
        endcase
    end

    assign st_ready = (count_q < DEPTH_C);
    assign enq      = st_valid && st_ready && (st_sel != 2'b11);
    assign pop      = (state_q == S_ISSUE) && dmem_ack;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            mem_d[wr_ptr_q] = enq_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
            default: if (pop && (count_d == '0)) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Outputs are gated so the write port sees zeros whenever no request is live.
    assign head       = mem_q[rd_ptr_q];
    assign dmem_req   = (state_q == S_ISSUE);
    assign dmem_addr  = dmem_req ? {head.waddr, 2'b00} : 32'h0;
    assign dmem_wdata = dmem_req ? head.data : 32'h0;
    assign dmem_we    = dmem_req ? head.mask : 4'h0;
    assign drain_idle = (count_q == '0) && (state_q == S_IDLE);
    assign count      = count_q;
endmodule

// File: doc/store_drain_ctrl.md
# store_drain_ctrl

Store queue and drain sequencer between the execute/memory stage and the data memory write port. It accepts committed stores (address, raw rs2 data, store size) from the pipeline and buffers them in a DEPTH-entry FIFO. It lane-aligns data and builds a byte-write mask at enqueue time, then issues the stores to dmem one at a time over a req/ack handshake. It back-pressures the pipeline when full and reports when all stores have drained, for fences and MMIO ordering.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- st_valid  in  1  pipeline presents a store this cycle
- st_addr  in  32  byte address of the store
- st_data  in  32  raw rs2 value; lane 0 holds the store data
- st_sel  in  2  00 SB, 01 SH, 10 SW, 11 no store
- st_ready  out  1  queue can accept a store this cycle
- dmem_req  out  1  write request valid
- dmem_addr  out  32  word address, bits [1:0] always 0
- dmem_wdata  out  32  lane-aligned write data
- dmem_we  out  4  byte write enables, bit i covers wdata[8i+7:8i]
- dmem_ack  in  1  dmem accepts the current request at this edge
- drain_idle  out  1  queue empty and no request outstanding
- count  out  clog2(DEPTH)+1  current occupancy

## Operation
- Enqueue:
  - Occurs when st_valid && st_ready && st_sel != 11.
  - A st_valid with st_sel = 11 is dropped silently.
- Offset o = st_addr[1:0]. Each entry stores {st_addr[31:2], 2'b00}, the shifted data, and the mask:
  - SB: data = st_data << 8*o; mask = 4'b0001 << o.
  - SH, o=00: data unshifted; mask 0011.
  - SH, o=01: data << 8; mask 0110.
  - SH, o=10 or 11: data << 16; mask 1100.
  - SW: data unshifted; mask 1111, whatever the value of o.
- Data bits outside the mask keep whatever the shift leaves; dmem must honour dmem_we.
- st_ready = (count < DEPTH), driven from registered state only. There is no same-cycle bypass when full, so an enqueue is refused while full even if a pop happens in the same cycle.
- FSM states:
  - IDLE: dmem_req = 0. Go to ISSUE when count > 0.
  - ISSUE: dmem_req = 1 and the dmem outputs show the FIFO head.
    - On dmem_ack, pop the head.
    - After the pop, stay in ISSUE if the post-pop count is above 0 (including a same-edge enqueue); otherwise return to IDLE.
- Head outputs must stay stable while dmem_req = 1 and no ack has arrived.
- Gating: dmem_addr, dmem_wdata and dmem_we read 0 whenever dmem_req = 0.
- dmem_ack is ignored in IDLE.
- Count update per edge: +1 on enqueue only, -1 on pop only, unchanged when both or neither occur.
- Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- drain_idle = (count == 0) && (state == IDLE).

## Timing
- Reset (asynchronous, takes effect immediately):
  - Pointers and count go to 0; state goes to IDLE.
  - dmem_req, dmem_addr, dmem_wdata and dmem_we go to 0.
  - st_ready = 1 and drain_idle = 1.
- Reset mid-transfer: dmem_req drops in the same cycle and all queued stores are discarded. No ack is expected afterwards.
- Issue latency: a store enqueued at edge E0 into an empty queue gives dmem_req = 1 after edge E1.
- Throughput: with dmem_ack held high, one store retires per cycle after the first. There is no bubble between back-to-back entries.
- A single-cycle ack at edge Ek makes the next head visible after Ek. If the queue is empty at that point, dmem_req = 0 after Ek.
- st_ready and count reflect the state after the previous edge.

## Test plan
- Reset, then SB with addr 0x1003 and data 0x12345678 -> dmem_addr 0x1000, wdata 0x78000000, we 1000. dmem_req rises 2 edges after st_valid.
- SH with addr 0x2001 and data 0x0000ABCD, then SH with addr 0x2002 -> first: wdata 0x00ABCD00, we 0110; second: wdata 0xABCD0000, we 1100. Both issue in order.
- SW with addr 0x3002, data 0xDEADBEEF, ack held low for 5 cycles -> dmem_req and all head fields are stable for 5 cycles. The entry pops on the edge where ack is sampled high; we reads 1111.
- Enqueue 5 stores with ack held low, DEPTH=4 -> st_ready goes 0 after the 4th and the 5th is refused. Raise ack -> stores 1–4 drain in FIFO order, one per cycle, and drain_idle rises after the last.
- Full-wrap check with ack toggling: sustain enqueue and pop for 3×DEPTH stores, including same-edge enqueue+pop at count=1 -> count holds at 1, state stays ISSUE, no store is lost or reordered, pointers wrap correctly. Also drive st_sel=11 with st_valid -> nothing enqueued.
- Assert rst while dmem_req = 1 with 3 entries queued -> req and the dmem outputs drop immediately, count = 0 and drain_idle = 1. After release, a new SB issues normally.
